// File: rtl/sha1_block_core.sv
// SHA-1 compression engine: takes 16 serial big-endian message words per block and
// runs 80 rounds (one per cycle) over a 16-word circular schedule, chaining H across blocks.
//
// state  | meaning
// IDLE   | reset-only state, moves to LOAD on the first clock after reset
// LOAD   | accepting message words W0..W15; init reloads the IV here
// ROUND  | one compression round per cycle, t = 0..79
// UPDATE | fold a..e into the chaining state, pulse digest_valid next cycle
module sha1_block_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init,
    input  logic         word_valid,
    input  logic [31:0]  word_in,
    output logic         word_ready,
    output logic         busy,
    output logic [159:0] digest,
    output logic         digest_valid
);

    localparam int ROUNDS = 80;

    localparam logic [31:0] IV0 = 32'h67452301;
    localparam logic [31:0] IV1 = 32'hEFCDAB89;
    localparam logic [31:0] IV2 = 32'h98BADCFE;
    localparam logic [31:0] IV3 = 32'h10325476;
    localparam logic [31:0] IV4 = 32'hC3D2E1F0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_UPDATE
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [6:0]   t_q, t_d;
    logic [31:0]  h_q [5];
    logic [31:0]  h_d [5];
    logic [31:0]  w_q [16];
    logic [31:0]  w_d [16];
    logic [31:0]  a_q, b_q, c_q, d_q, e_q;
    logic [31:0]  a_d, b_d, c_d, d_d, e_d;
    logic         dv_q, dv_d;

    logic [3:0]   idx;
    logic [31:0]  w_mix;
    logic [31:0]  w_new;
    logic [31:0]  w_t;
    logic [31:0]  f_t;
    logic [31:0]  k_t;
    logic [31:0]  temp;

    // Schedule slots relative to t mod 16: t-3, t-8, t-14 (== t+2), t-16 (== t).
    always_comb begin
        idx   = t_q[3:0];
        w_mix = w_q[idx - 4'd3] ^ w_q[idx - 4'd8] ^ w_q[idx + 4'd2] ^ w_q[idx];
        w_new = {w_mix[30:0], w_mix[31]};
        w_t   = (t_q < 7'd16) ? w_q[idx] : w_new;

        if (t_q < 7'd20) begin
            f_t = (b_q & c_q) | (~b_q & d_q);
            k_t = 32'h5A827999;
        end else if (t_q < 7'd40) begin
            f_t = b_q ^ c_q ^ d_q;
            k_t = 32'h6ED9EBA1;
        end else if (t_q < 7'd60) begin
            f_t = (b_q & c_q) | (b_q & d_q) | (c_q & d_q);
            k_t = 32'h8F1BBCDC;
        end else begin
            f_t = b_q ^ c_q ^ d_q;
            k_t = 32'hCA62C1D6;
        end

        temp = {a_q[26:0], a_q[31:27]} + f_t + e_q + k_t + w_t;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        h_d     = h_q;
        w_d     = w_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        e_d     = e_q;
        dv_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (init) begin
                    h_d[0] = IV0;
                    h_d[1] = IV1;
                    h_d[2] = IV2;
                    h_d[3] = IV3;
                    h_d[4] = IV4;
                    cnt_d  = 4'd0;
                end else if (word_valid) begin
                    w_d[cnt_q] = word_in;
                    cnt_d      = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        a_d     = h_q[0];
                        b_d     = h_q[1];
                        c_d     = h_q[2];
                        d_d     = h_q[3];
                        e_d     = h_q[4];
                        t_d     = 7'd0;
                        state_d = S_ROUND;
                    end
                end
            end
            S_ROUND: begin
                if (t_q >= 7'd16) begin
                    w_d[idx] = w_new;
                end
                e_d = d_q;
                d_d = c_q;
                c_d = {b_q[1:0], b_q[31:2]};
                b_d = a_q;
                a_d = temp;
                t_d = t_q + 7'd1;
                if (t_q == 7'(ROUNDS - 1)) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                h_d[0]  = h_q[0] + a_q;
                h_d[1]  = h_q[1] + b_q;
                h_d[2]  = h_q[2] + c_q;
                h_d[3]  = h_q[3] + d_q;
                h_d[4]  = h_q[4] + e_q;
                cnt_d   = 4'd0;
                dv_d    = 1'b1;
                state_d = S_LOAD;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            t_q     <= 7'd0;
            h_q[0]  <= IV0;
            h_q[1]  <= IV1;
            h_q[2]  <= IV2;
            h_q[3]  <= IV3;
            h_q[4]  <= IV4;
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= 32'd0;
            end
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            c_q     <= 32'd0;
            d_q     <= 32'd0;
            e_q     <= 32'd0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            h_q     <= h_d;
            w_q     <= w_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            e_q     <= e_d;
            dv_q    <= dv_d;
        end
    end

    assign word_ready   = (state_q == S_LOAD);
    assign busy         = (state_q == S_ROUND) || (state_q == S_UPDATE);
    assign digest       = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4]};
    assign digest_valid = dv_q;

endmodule

// File: tb/tb_sha1_block_core.sv
// Bench for sha1_block_core: expected digests are queued as blocks are driven and
// compared when digest_valid pulses, alongside latency and handshake checks.
`timescale 1ns/1ps
module tb_sha1_block_core;

    localparam logic [159:0] IV_DIG    = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
    localparam logic [159:0] ABC_DIG   = 160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D;
    localparam logic [159:0] EMPTY_DIG = 160'hDA39A3EE_5E6B4B0D_3255BFEF_95601890_AFD80709;
    localparam logic [159:0] TWO_DIG   = 160'h84983E44_1C3BD26E_BAAE4AA1_F95129E5_E54670F1;

    logic         clk;
    logic         rst_n;
    logic         init;
    logic         word_valid;
    logic [31:0]  word_in;
    logic         word_ready;
    logic         busy;
    logic [159:0] digest;
    logic         digest_valid;

    sha1_block_core dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .init         (init),
        .word_valid   (word_valid),
        .word_in      (word_in),
        .word_ready   (word_ready),
        .busy         (busy),
        .digest       (digest),
        .digest_valid (digest_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           acc_cyc  = 0;
    int           n_dv     = 0;
    logic         dv_prev  = 1'b0;
    logic [159:0] sb_q [$];
    logic [159:0] h_cur;
    logic [31:0]  blk_buf [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference compression with a flat 80-word schedule.
    function automatic logic [159:0] sha1_ref(input logic [159:0] hin, input logic [31:0] blk [16]);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, tmp;
        for (int t = 0; t < 80; t++) begin
            if (t < 16) w[t] = blk[t];
            else begin
                tmp  = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
                w[t] = {tmp[30:0], tmp[31]};
            end
        end
        {a, b, c, d, e} = hin;
        for (int t = 0; t < 80; t++) begin
            if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
            else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
        end
        return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (dv_prev) check_eq("dv_one_cycle", {159'd0, digest_valid}, 160'd0);
            if (digest_valid) begin
                n_dv++;
                if (sb_q.size() == 0) begin
                    check_eq("dv_unexpected", 160'd1, 160'd0);
                end else begin
                    check_eq("digest", digest, sb_q.pop_front());
                    check_eq("latency", 160'(cyc - acc_cyc), 160'd81);
                end
            end
            if (busy) check_eq("ready_in_busy", {159'd0, word_ready}, 160'd0);
        end
        dv_prev = rst_n && digest_valid;
    end

    task automatic load_abc();
        for (int i = 0; i < 16; i++) blk_buf[i] = 32'd0;
        blk_buf[0]  = 32'h61626380;
        blk_buf[15] = 32'h00000018;
    endtask

    task automatic load_empty();
        for (int i = 0; i < 16; i++) blk_buf[i] = 32'd0;
        blk_buf[0] = 32'h80000000;
    endtask

    task automatic pulse_init();
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
    endtask

    task automatic send_words(input int n, input bit gaps);
        int g;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                word_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            word_valid = 1'b1;
            word_in    = blk_buf[i];
            g = 0;
            while (!word_ready && g < 300) begin
                @(negedge clk);
                g++;
            end
            if (!word_ready) begin
                check_eq("ready_timeout", 160'd0, 160'd1);
                word_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            acc_cyc    = cyc;
            word_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic send_block(input logic [159:0] exp, input bit gaps);
        sb_q.push_back(exp);
        h_cur = exp;
        send_words(16, gaps);
    endtask

    task automatic wait_done();
        int g = 0;
        while (sb_q.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (sb_q.size() != 0) begin
            check_eq("done_timeout", 160'd0, 160'd1);
            sb_q.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst_n      = 1'b0;
        init       = 1'b0;
        word_valid = 1'b0;
        word_in    = 32'd0;
        h_cur      = IV_DIG;
        repeat (3) @(negedge clk);
        check_eq("rst_digest", digest, IV_DIG);
        check_eq("rst_ready", {159'd0, word_ready}, 160'd0);
        check_eq("rst_busy", {159'd0, busy}, 160'd0);
        check_eq("rst_dv", {159'd0, digest_valid}, 160'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst", {159'd0, word_ready}, 160'd1);

        // "abc"
        pulse_init();
        load_abc();
        send_block(ABC_DIG, 1'b0);
        wait_done();
        check_eq("abc_hold", digest, ABC_DIG);

        // empty message
        pulse_init();
        load_empty();
        send_block(EMPTY_DIG, 1'b0);
        wait_done();

        // chaining without init
        load_abc();
        send_block(sha1_ref(h_cur, blk_buf), 1'b0);
        wait_done();

        // two-block message
        pulse_init();
        n0 = n_dv;
        blk_buf = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                    32'h65666768, 32'h66676869, 32'h6768696A, 32'h68696A6B,
                    32'h696A6B6C, 32'h6A6B6C6D, 32'h6B6C6D6E, 32'h6C6D6E6F,
                    32'h6D6E6F70, 32'h6E6F7071, 32'h80000000, 32'h00000000};
        send_block(sha1_ref(IV_DIG, blk_buf), 1'b0);
        for (int i = 0; i < 16; i++) blk_buf[i] = 32'd0;
        blk_buf[15] = 32'h000001C0;
        send_block(TWO_DIG, 1'b0);
        wait_done();
        check_eq("two_block_pulses", 160'(n_dv - n0), 160'd2);

        // gapped input, valid held high through ROUND
        pulse_init();
        load_abc();
        send_block(ABC_DIG, 1'b1);
        word_valid = 1'b1;
        word_in    = 32'hDEADBEEF;
        repeat (75) @(negedge clk);
        word_valid = 1'b0;
        wait_done();

        // abort: partial block, then init together with a word
        load_abc();
        send_words(5, 1'b0);
        init       = 1'b1;
        word_valid = 1'b1;
        word_in    = 32'hCAFEF00D;
        @(negedge clk);
        init       = 1'b0;
        word_valid = 1'b0;
        check_eq("init_loads_iv", digest, IV_DIG);
        send_block(ABC_DIG, 1'b0);
        wait_done();

        // init during ROUND is ignored
        pulse_init();
        send_block(ABC_DIG, 1'b0);
        repeat (30) @(negedge clk);
        pulse_init();
        wait_done();
        check_eq("init_in_round", digest, ABC_DIG);

        // reset mid-ROUND
        pulse_init();
        send_block(ABC_DIG, 1'b0);
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_digest", digest, IV_DIG);
        check_eq("midrst_ready", {159'd0, word_ready}, 160'd0);
        check_eq("midrst_busy", {159'd0, busy}, 160'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_block(ABC_DIG, 1'b0);
        wait_done();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sha1_block_core.md
Name: sha1_block_core

Overview:
- SHA-1 compression engine directly downstream of the ipad/opad word padders in the HMAC-SHA1 datapath.
- Accepts a 512-bit message block as 16 serial 32-bit words (big-endian, W0 first) under a valid/ready handshake.
- Runs the 80-round SHA-1 compression, one round per cycle, using a 16-word circular schedule buffer.
- Holds a 160-bit chaining state across blocks and presents the digest after each block.

Parameters:
- ROUNDS, 80, number of compression rounds; fixed by SHA-1, not to be overridden.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- init  input  1  load SHA-1 initial hash values into the chaining state; single-cycle pulse
- word_valid  input  1  word_in holds a valid message word
- word_in  input  32  message word, W[t] in big-endian order
- word_ready  output  1  core can accept a word this cycle
- busy  output  1  compression or update in progress
- digest  output  160  chaining state {H0,H1,H2,H3,H4}, H0 in [159:128]
- digest_valid  output  1  one-cycle pulse when digest is updated after a block

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, word count=0, round count=0.
  - H0..H4 = 67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0.
  - digest reflects those values; word_ready=0 during reset; busy=0, digest_valid=0.
- FSM states:
  - LOAD (entered from IDLE on the first cycle after reset; IDLE is the reset-only state):
    - word_ready=1.
    - Word accepted when word_valid&&word_ready at the clock edge; stored in W[cnt]; cnt increments.
    - On acceptance of the 16th word (cnt==15): a..e <= H0..H4, round t=0, go to ROUND.
  - ROUND:
    - word_ready=0, busy=1; word_valid is ignored, no words are stored.
    - Each cycle performs round t.
    - For t<16, W[t] comes from the buffer.
    - For t>=16, W[t] = ROTL1(W[t-3]^W[t-8]^W[t-14]^W[t-16]), computed from circular index t mod 16 and written back to slot t mod 16.
    - f/K per round range:
      - 0-19: Ch, K=5A827999
      - 20-39: Parity, K=6ED9EBA1
      - 40-59: Maj, K=8F1BBCDC
      - 60-79: Parity, K=CA62C1D6
    - Round update: temp = ROTL5(a)+f+e+K+W (mod 2^32); e<=d; d<=c; c<=ROTL30(b); b<=a; a<=temp.
    - After t=79, go to UPDATE.
  - UPDATE:
    - busy=1; H_i <= H_i + {a..e}_i (mod 2^32).
    - Next state LOAD with cnt=0; digest_valid=1 in the following cycle only.
- Latency: 16th word accepted at edge N. Rounds occur at edges N+1..N+80. H updates at edge N+81. digest_valid is high during the cycle after edge N+81; word_ready returns high in that same cycle.
- digest is registered and changes only at UPDATE, init, or reset. It is stable between updates.
- init:
  - Honoured only in LOAD: H <= IV and cnt <= 0, aborting any partial block.
  - If init and a word acceptance occur in the same cycle, init wins and the word is dropped.
  - Ignored in ROUND/UPDATE.
- Multi-block messages: without init, the next block chains from the current H.
- Reset mid-operation: all state returns to reset values immediately; a partial block is discarded.

Test Plan:
- "abc": init, then words 61626380, 0x14 zero words, 00000018 -> digest A9993E36 4706816A BA3E2571 7850C26C 9CD0D89D; digest_valid exactly 81 cycles after the 16th-word edge.
- Empty message: init, then words 80000000, 0x15 zeros -> DA39A3EE 5E6B4B0D 3255BFEF 95601890 AFD80709.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (448 bits), init once -> 84983E44 1C3BD26E BAAE4AA1 F95129E5 E54670F1; digest_valid pulses twice.
- Gapped input: "abc" block with word_valid deasserted randomly, plus word_valid held high during ROUND -> same digest as the "abc" case; word_ready=0 throughout ROUND/UPDATE; no extra words stored.
- Abort: 5 words, then init, then the full "abc" block -> "abc" digest. Separately, init pulsed during ROUND -> ignored, digest correct.
- Reset mid-ROUND (rst_n low at round 40) -> digest=IV and word_ready=0 during reset; after release, the "abc" block yields the correct digest.
